// File: rtl/led_fader_pkg.sv
// Shared types and the duty mapping for the LED fader.
// Define LED_FADER_GAMMA_EN for a squared (perceptual) brightness curve; the default is linear.
package led_fader_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } chan_state_e;

  // Widest brightness supported by duty_f; channels cast in and out of this width.
  localparam int unsigned DUTY_W_MAX = 16;

  function automatic logic [DUTY_W_MAX-1:0] duty_f(input logic [DUTY_W_MAX-1:0] b,
                                                   input int unsigned            bw);
`ifdef LED_FADER_GAMMA_EN
    logic [2*DUTY_W_MAX-1:0] prod;
    prod = {{DUTY_W_MAX{1'b0}}, b} * {{DUTY_W_MAX{1'b0}}, b};
    prod = prod >> bw;
    return prod[DUTY_W_MAX-1:0];
`else
    logic [DUTY_W_MAX-1:0] mask;
    mask = DUTY_W_MAX'((32'd1 << bw) - 32'd1);
    return b & mask;
`endif
  endfunction

endpackage

// File: rtl/led_fader_chan.sv
// One fade channel: ramp FSM, brightness level b, and the registered PWM pin.
// Duty curve follows LED_FADER_GAMMA_EN through led_fader_pkg::duty_f.
module led_fader_chan
  import led_fader_pkg::*;
#(
  parameter int unsigned BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          period_end,
  input  logic [BW-1:0] pwm_cnt,
  input  logic          bypass,
  output logic          led,
  output logic          ramping
);

  localparam logic [BW-1:0] MAX = '1;

  chan_state_e   state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [BW-1:0] duty;
  logic          led_q, led_d;

  assign duty = BW'(duty_f(DUTY_W_MAX'(b_q), BW));

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    b_d     = b_q;
    if (period_end) begin
      unique case (state_q)
        ST_OFF: begin
          if (req) begin
            b_d     = BW'(1);
            state_d = ST_RAMP_UP;
          end
        end
        ST_ON: begin
          if (!req) begin
            b_d     = MAX - 1'b1;
            state_d = ST_RAMP_DOWN;
          end
        end
        ST_RAMP_UP, ST_RAMP_DOWN: begin
          // b stays within 1..MAX-1 while ramping, so neither step can wrap.
          if (req) begin
            b_d     = b_q + 1'b1;
            state_d = (b_d == MAX) ? ST_ON : ST_RAMP_UP;
          end else begin
            b_d     = b_q - 1'b1;
            state_d = (b_d == '0) ? ST_OFF : ST_RAMP_DOWN;
          end
        end
      endcase
    end
  end

  always_comb begin
    led_d = 1'b0;
    if (bypass) begin
      led_d = req;
    end else begin
      unique case (state_q)
        ST_ON:   led_d = 1'b1;
        ST_OFF:  led_d = 1'b0;
        default: led_d = (duty > pwm_cnt);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      state_q <= ST_OFF;
      b_q     <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      led_q   <= led_d;
    end
  end

  assign led     = led_q;
  assign ramping = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

endmodule

// File: rtl/led_fader.sv
// PWM fader between the LED register and the board pins: shared prescaler and PWM counter,
// one led_fader_chan per pin, registered busy flag. Gamma curve via LED_FADER_GAMMA_EN.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned N_LEDS       = 32,
  parameter int unsigned BW           = 8,
  parameter int unsigned PRESCALE_DIV = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] leds_i,
  input  logic              bypass_i,
  output logic [N_LEDS-1:0] led_o,
  output logic              busy_o
);

  localparam int unsigned      PS_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE_DIV - 1);
  localparam logic [BW-1:0]    MAX     = '1;

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [BW-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              period_end;
  logic [N_LEDS-1:0] ramping;

  // With PRESCALE_DIV == 1 the prescaler is pinned at 0 and ticks every clock.
  assign tick       = (presc_q == PS_LAST);
  assign period_end = tick && (pwm_cnt_q == MAX);

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    busy_d    = |ramping;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    led_fader_chan #(
      .BW(BW)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .req       (leds_i[i]),
      .period_end(period_end),
      .pwm_cnt   (pwm_cnt_q),
      .bypass    (bypass_i),
      .led       (led_o[i]),
      .ramping   (ramping[i])
    );
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with BW=4, PRESCALE_DIV=1: one PWM period is 16 clocks.
// Expected duty counts follow LED_FADER_GAMMA_EN when it is defined for the build.
module tb_led_fader;

  localparam int MAXV = 15;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic [31:0] leds_i   = '1;
  logic        bypass_i = 1'b0;
  logic [31:0] led_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_fader #(
    .N_LEDS      (32),
    .BW          (4),
    .PRESCALE_DIV(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .leds_i  (leds_i),
    .bypass_i(bypass_i),
    .led_o   (led_o),
    .busy_o  (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_duty(input int b);
`ifdef LED_FADER_GAMMA_EN
    return (b * b) >> 4;
`else
    return b;
`endif
  endfunction

  // One 16-clock PWM period in which ch0 holds brightness b; b==15 means ON, b==0 means OFF.
  // req_next is the ch0 request seen at the period_end that closes this period.
  task automatic run_period(input logic req_next, input int b);
    int   ones;
    logic others;
    int   expc;
    ones   = 0;
    others = 1'b0;
    expc   = (b == MAXV) ? 16 : (b == 0) ? 0 : exp_duty(b);
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) begin
        check($sformatf("busy_b%0d", b), {31'b0, busy_o}, {31'b0, (b != 0 && b != MAXV)});
        leds_i = {31'b0, req_next};
      end
      ones   += int'(led_o[0]);
      others |= |led_o[31:1];
    end
    check($sformatf("duty_b%0d", b), 32'(ones), 32'(expc));
    check($sformatf("others_b%0d", b), {31'b0, others}, 32'd0);
  endtask

  // First 16 clocks after reset release: leds_i changes mid-period must be ignored.
  task automatic period0(input string tag, input logic [31:0] early, input logic [31:0] late);
    leds_i = early;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 8) leds_i = late;
      if (i == 15) begin
        check({tag, "_busy15"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_led15"}, led_o, 32'd0);
      end
    end
    check({tag, "_busy16"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic mis;

    // Reset held with all requests high.
    repeat (3) step();
    check("rst_led", led_o, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);

    // Release and full ramp of ch0 up to ON.
    rst = 1'b1;
    period0("p0", 32'hFFFF_FFFF, 32'h0000_0001);
    for (int k = 1; k <= 14; k++) run_period(1'b1, k);
    run_period(1'b1, 15);
    run_period(1'b0, 15);

    // Ramp down from ON, reverse at b=3, then clear again at b=7 and fall to OFF.
    for (int k = 14; k >= 4; k--) run_period(1'b0, k);
    run_period(1'b1, 3);
    run_period(1'b1, 4);
    run_period(1'b1, 5);
    run_period(1'b1, 6);
    run_period(1'b0, 7);
    for (int k = 6; k >= 1; k--) run_period(1'b0, k);
    run_period(1'b0, 0);

    // Bypass: pins follow leds_i one clock later while ch0 keeps fading underneath.
    bypass_i = 1'b1;
    leds_i   = 32'h0000_00A5;
    step();
    check("byp_a5", led_o, 32'h0000_00A5);
    leds_i = 32'h0000_0001;
    step();
    check("byp_01", led_o, 32'h0000_0001);
    mis = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      mis |= (led_o !== 32'h0000_0001);
    end
    check("byp_hold", {31'b0, mis}, 32'd0);
    check("byp_busy", {31'b0, busy_o}, 32'd1);
    bypass_i = 1'b0;
    for (int k = 2; k <= 8; k++) run_period(1'b1, k);

    // Async reset in the middle of the b=9 period.
    repeat (3) step();
    check("pre_rst_busy", {31'b0, busy_o}, 32'd1);
    check("pre_rst_led", led_o, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_led", led_o, 32'd0);
    check("arst_busy", {31'b0, busy_o}, 32'd0);
    step();
    step();
    check("arst_hold_led", led_o, 32'd0);
    rst = 1'b1;
    period0("r0", 32'h0000_0001, 32'h0000_0001);
    run_period(1'b1, 1);
    run_period(1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
